// File: rtl/tdm_frame_sequencer.sv
// tdm_frame_sequencer
// Master-side frame timing controller for the TDM receive path. Generates
// tdm_sync, walks a bit counter through the channel slots and the trailing
// gap, and hands each completed frame to the consumer through a valid/ack
// handshake with sticky overrun detection and a wrapping frame counter.
//
// Ports:
//   tdm_clk      bit clock, all logic on its rising edge
//   reset        asynchronous, active-high
//   enable       level-sensitive run request
//   slot_mask    per-slot enable, latched at each frame start
//   frame_ack    consumer accepts the pending frame
//   ovr_clr      clears the sticky overrun flag
//   tdm_sync     one-cycle pulse in the cycle before bit 0
//   slot_idx     current slot number
//   bit_idx      bit position within the current slot
//   slot_active  current bit lies in an enabled slot
//   frame_done   one-cycle pulse in the first gap cycle
//   frame_valid  a completed frame is waiting for frame_ack
//   overrun      sticky; a frame completed while the previous was unacked
//   frame_count  completed-frame counter, wraps 0xFFFF -> 0
//   busy         high while a frame is being sequenced (SYNC or RUN)
module tdm_frame_sequencer #(
    parameter int SLOT_BITS = 32,
    parameter int NUM_SLOTS = 5,
    parameter int FRAME_LEN = 192,
    parameter int CNT_W     = 8
) (
    input  logic                         tdm_clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_SLOTS-1:0]         slot_mask,
    input  logic                         frame_ack,
    input  logic                         ovr_clr,
    output logic                         tdm_sync,
    output logic [2:0]                   slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         slot_active,
    output logic                         frame_done,
    output logic                         frame_valid,
    output logic                         overrun,
    output logic [15:0]                  frame_count,
    output logic                         busy
);

    localparam int SB_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(NUM_SLOTS * SLOT_BITS);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(NUM_SLOTS * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [NUM_SLOTS-1:0] mask_q;
    logic                 mask_load;
    logic                 en_q;
    logic                 at_last;
    logic                 in_slots;
    logic                 done_next;
    logic [CNT_W-1:0]     slot_pos;
    logic [7:0]           mask_ext;

    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The continue-or-stop decision at the last frame bit uses enable as
    // sampled on the previous edge (en_q), so tdm_sync has no path from any
    // input. The same registered value steers the state so sync and wrap
    // always agree.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        mask_load  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                cnt_next   = '0;
                mask_load  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (at_last) begin
                    cnt_next = '0;
                    if (en_q) begin
                        mask_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // frame_done is registered off the last slot bit so it lands in the
    // first gap cycle. A done coinciding with an ack keeps frame_valid set
    // because a fresh frame is now pending; overrun set beats ovr_clr.
    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            mask_q      <= '0;
            en_q        <= 1'b0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            bit_cnt    <= cnt_next;
            en_q       <= enable;
            frame_done <= done_next;
            if (mask_load) begin
                mask_q <= slot_mask;
            end
            if (frame_done) begin
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
                if (frame_valid && !frame_ack) begin
                    overrun <= 1'b1;
                end else if (ovr_clr) begin
                    overrun <= 1'b0;
                end
            end else begin
                if (frame_ack && frame_valid) begin
                    frame_valid <= 1'b0;
                end
                if (ovr_clr) begin
                    overrun <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        at_last   = (bit_cnt == LAST_CNT);
        in_slots  = (bit_cnt < SLOT_END);
        done_next = (state == RUN) && (bit_cnt == DONE_CNT);
        slot_pos  = bit_cnt >> SB_W;
        mask_ext  = 8'(mask_q);
        busy      = (state != IDLE);
        tdm_sync  = (state == SYNC) || ((state == RUN) && at_last && en_q);

        slot_idx    = '0;
        bit_idx     = '0;
        slot_active = 1'b0;
        if (state == RUN) begin
            if (in_slots) begin
                slot_idx    = slot_pos[2:0];
                bit_idx     = bit_cnt[SB_W-1:0];
                slot_active = mask_ext[slot_pos[2:0]];
            end else begin
                // Gap: hold the position of the final slot bit.
                slot_idx = 3'(NUM_SLOTS - 1);
                bit_idx  = '1;
            end
        end
    end

endmodule

// File: doc/tdm_frame_sequencer.md
Name: tdm_frame_sequencer

Overview:
- Master-side controller for the TDM receive path: generates tdm_sync and sequences frame timing on tdm_clk.
- Exposes slot and bit position plus a per-slot capture enable for the channel deserializer, with a mask of active channels.
- Hands completed frames to the downstream consumer via a valid/ack handshake, with overrun detection and a frame counter.

Parameters:
- SLOT_BITS, 32, bit periods per channel slot; power of 2.
- NUM_SLOTS, 5, channel slots per frame; 1..8.
- FRAME_LEN, 192, total bit periods per frame, slots plus gap; must be > NUM_SLOTS*SLOT_BITS.
- CNT_W, 8, bit-counter width; 2^CNT_W >= FRAME_LEN.

Ports:
- tdm_clk  input  1  bit clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  run request; level-sensitive.
- slot_mask  input  NUM_SLOTS  per-slot enable; bit n gates slot n.
- frame_ack  input  1  consumer accepts the pending frame.
- ovr_clr  input  1  clears the overrun flag.
- tdm_sync  output  1  frame sync; one-cycle pulse preceding bit 0.
- slot_idx  output  3  current slot number.
- bit_idx  output  log2(SLOT_BITS)  bit position within the slot.
- slot_active  output  1  current bit lies in an enabled slot.
- frame_done  output  1  one-cycle pulse; last slot bit completed.
- frame_valid  output  1  completed frame awaiting ack.
- overrun  output  1  sticky; a frame completed while the previous one was unacked.
- frame_count  output  16  completed-frame counter; wraps 0xFFFF->0.
- busy  output  1  high in SYNC or RUN.

Behaviour:
- Reset (async): state=IDLE, bit_cnt=0, latched mask=0, all outputs 0. Reset mid-frame aborts the frame immediately; no frame_done is produced.
- States: IDLE, SYNC, RUN.
- IDLE: busy=0, slot_active=0, slot_idx=0, bit_idx=0. If enable=1, go to SYNC next edge.
- SYNC (one cycle): tdm_sync=1. slot_mask is latched into mask_q on this edge. bit_cnt<=0. Next state RUN.
- RUN: bit_cnt increments by 1 per cycle.
  - Slot region, bit_cnt < NUM_SLOTS*SLOT_BITS:
    - slot_idx = bit_cnt / SLOT_BITS
    - bit_idx = bit_cnt % SLOT_BITS
    - slot_active = mask_q[slot_idx]
  - Gap region: slot_active=0, slot_idx=NUM_SLOTS-1, bit_idx=SLOT_BITS-1 (held).
  - frame_done=1 (registered) during the cycle where bit_cnt == NUM_SLOTS*SLOT_BITS, i.e. the first gap cycle.
  - At bit_cnt == FRAME_LEN-1:
    - if enable=1: tdm_sync=1 in this same cycle, mask_q reloads, bit_cnt wraps to 0, state stays RUN.
    - else: go to IDLE; no sync.
  - Deasserting enable mid-frame always completes the current frame, including frame_done.
- Combinational outputs: slot_idx, bit_idx, slot_active and tdm_sync derive from registered state/bit_cnt only; they have no input-to-output combinational paths.
- Frame spacing: sync-to-sync is exactly FRAME_LEN cycles in continuous run. The first frame after IDLE starts 2 cycles after enable rises.
- Handshake:
  - frame_valid sets on the edge ending a frame_done cycle.
  - frame_valid clears on an edge where frame_ack=1 and frame_valid=1.
  - frame_ack while frame_valid=0 is ignored.
- Overrun:
  - frame_done while frame_valid=1 and frame_ack=0 -> overrun<=1; frame_valid stays 1.
  - frame_done with frame_ack=1 in the same cycle -> frame_valid stays 1, no overrun.
  - ovr_clr clears overrun. If a new overrun and ovr_clr coincide, set wins.
- frame_count increments on every frame_done, regardless of overrun.
- slot_mask changes mid-frame have no effect until the next SYNC/wrap.
- mask_q=0 is legal: full timing runs, slot_active is never 1, frame_done still pulses.

Test Plan:
- Reset, then enable=1 at cycle 0, mask=5'b11111: tdm_sync=1 at cycle 1; slot_idx=0/bit_idx=0 at cycle 2; slot_idx=4/bit_idx=31 at cycle 161; frame_done at cycle 162; next tdm_sync at cycle 193; sync period 192.
- mask=5'b00101: slot_active=1 only for bit_cnt 0..31 and 64..95. Change mask to 5'b11111 at bit_cnt 40: no effect until the next frame.
- Continuous run, frame_ack never asserted: after 2 frames, frame_valid=1, overrun=1, frame_count=2. Pulse ovr_clr: overrun=0, frame_valid still 1.
- frame_ack asserted exactly in the frame_done cycle of frame 2 (frame 1 pending): frame_valid=1, overrun=0.
- enable dropped at bit_cnt 50: frame completes, frame_done pulses, no further tdm_sync, IDLE after bit_cnt 191, busy=0.
- reset pulsed at bit_cnt 100: all outputs 0 immediately, no frame_done; with enable held, re-sync occurs 2 cycles after reset release.
